// File: rtl/hilo_unit.sv
// HI/LO register unit and sequencer for the iterative divider.
// Handles MULT/MTHI/MTLO in one cycle and stalls EX while a DIV runs.
module hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div,
    input  logic        ex_mult,
    input  logic        ex_sign,
    input  logic [31:0] ex_op_a,
    input  logic [31:0] ex_op_b,
    input  logic        ex_mthi,
    input  logic        ex_mtlo,
    input  logic [31:0] ex_wdata,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_fg,
    output logic        div_sg,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_wrp,
    input  logic        div_fin,
    input  logic [63:0] div_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  dc_q, dc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] div_a_q, div_a_d;
    logic [31:0] div_b_q, div_b_d;
    logic        div_fg_q, div_fg_d;
    logic        div_sg_q, div_sg_d;
    logic [63:0] ext_a, ext_b, prod;

    always_comb begin
        ext_a = ex_sign ? {{32{ex_op_a[31]}}, ex_op_a} : {32'b0, ex_op_a};
        ext_b = ex_sign ? {{32{ex_op_b[31]}}, ex_op_b} : {32'b0, ex_op_b};
        // Low 64 bits of the extended product are exact for both signednesses.
        prod  = ext_a * ext_b;

        state_d  = state_q;
        dc_d     = dc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_a_d  = div_a_q;
        div_b_d  = div_b_q;
        div_fg_d = div_fg_q;
        div_sg_d = div_sg_q;

        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (ex_div) begin
                    div_a_d  = ex_op_a;
                    div_b_d  = ex_op_b;
                    div_sg_d = ex_sign;
                    div_fg_d = 1'b1;
                    state_d  = S_WAIT;
                end else if (ex_mult) begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else begin
                    if (ex_mthi) hi_d = ex_wdata;
                    if (ex_mtlo) lo_d = ex_wdata;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    div_fg_d = 1'b0;
                    dc_d     = 2'd2;
                    state_d  = S_DRAIN;
                end else if (div_fin) begin
                    hi_d     = div_out[63:32];
                    lo_d     = div_out[31:0];
                    div_fg_d = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                // Holds abort until the divider is out of its zero/result states.
                if (dc_q <= 2'd1) begin
                    dc_d    = 2'd0;
                    state_d = S_IDLE;
                end else begin
                    dc_d = dc_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dc_q     <= 2'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            div_a_q  <= 32'd0;
            div_b_q  <= 32'd0;
            div_fg_q <= 1'b0;
            div_sg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dc_q     <= dc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            div_a_q  <= div_a_d;
            div_b_q  <= div_b_d;
            div_fg_q <= div_fg_d;
            div_sg_q <= div_sg_d;
        end
    end

    assign stall   = ((state_q == S_IDLE) && ex_div && !flush)
                   || (state_q == S_WAIT);
    assign div_wrp = flush || (state_q == S_DRAIN);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign div_fg  = div_fg_q;
    assign div_sg  = div_sg_q;
    assign div_a   = div_a_q;
    assign div_b   = div_b_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit with a behavioural divider and HI/LO reference model.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div, ex_mult, ex_sign;
    logic [31:0] ex_op_a, ex_op_b;
    logic        ex_mthi, ex_mtlo;
    logic [31:0] ex_wdata;
    logic        flush;
    logic        stall;
    logic [31:0] hi, lo;
    logic        div_fg, div_sg;
    logic [31:0] div_a, div_b;
    logic        div_wrp;
    logic        div_fin;
    logic [63:0] div_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi, exp_lo;

    hilo_unit dut (
        .clk(clk), .rst(rst),
        .ex_div(ex_div), .ex_mult(ex_mult), .ex_sign(ex_sign),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo), .ex_wdata(ex_wdata),
        .flush(flush), .stall(stall), .hi(hi), .lo(lo),
        .div_fg(div_fg), .div_sg(div_sg), .div_a(div_a), .div_b(div_b),
        .div_wrp(div_wrp), .div_fin(div_fin), .div_out(div_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] divref(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic sg);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [63:0] mulref(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic sg);
        longint p;
        if (sg) p = longint'($signed(a)) * longint'($signed(b));
        else    return {32'd0, a} * {32'd0, b};
        return p;
    endfunction

    // Stand-in for the iterative divider: latch, 33 steps, finish.
    logic [1:0]  dv_st;
    int          dv_cnt;
    logic [31:0] dv_a, dv_b;
    logic        dv_sg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_st   <= 2'd0;
            dv_cnt  <= 0;
            div_fin <= 1'b0;
            div_out <= 64'd0;
            dv_a    <= 32'd0;
            dv_b    <= 32'd0;
            dv_sg   <= 1'b0;
        end else begin
            case (dv_st)
                2'd0: begin
                    div_fin <= 1'b0;
                    if (div_fg && !div_wrp) begin
                        dv_st  <= 2'd1;
                        dv_cnt <= (div_b == 32'd0) ? 0 : 32;
                        dv_a   <= div_a;
                        dv_b   <= div_b;
                        dv_sg  <= div_sg;
                    end
                end
                2'd1: begin
                    if (div_wrp) dv_st <= 2'd0;
                    else if (dv_cnt == 0) begin
                        div_fin <= 1'b1;
                        div_out <= divref(dv_a, dv_b, dv_sg);
                        dv_st   <= 2'd2;
                    end else dv_cnt <= dv_cnt - 1;
                end
                default: begin
                    if (div_wrp || !div_fg) begin
                        div_fin <= 1'b0;
                        dv_st   <= 2'd0;
                    end
                end
            endcase
        end
    end

    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input logic sg);
        int n;
        logic done;
        @(negedge clk);
        ex_div = 1'b1; ex_sign = sg; ex_op_a = a; ex_op_b = b;
        n = 0; done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            n++;
            if (i == 1) chk("div_ops", {div_sg, div_a, div_b},
                            {sg, a, b});
            @(negedge clk);
        end
        chk("div_timeout", {63'd0, done}, 64'd1);
        chk("div_fg_done", {63'd0, div_fg}, 64'd0);
        chk("div_stall_cyc", n, (b == 32'd0) ? 4 : 36);
        ex_div = 1'b0; ex_sign = 1'b0;
        {exp_hi, exp_lo} = divref(a, b, sg);
        chk("div_hilo", {hi, lo}, {exp_hi, exp_lo});
    endtask

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic sg);
        @(negedge clk);
        ex_mult = 1'b1; ex_sign = sg; ex_op_a = a; ex_op_b = b;
        #1 chk("mult_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        ex_mult = 1'b0; ex_sign = 1'b0;
        {exp_hi, exp_lo} = mulref(a, b, sg);
        chk("mult_hilo", {hi, lo}, {exp_hi, exp_lo});
    endtask

    task automatic do_mt(input logic wh, input logic wl,
                         input logic [31:0] d);
        @(negedge clk);
        ex_mthi = wh; ex_mtlo = wl; ex_wdata = d;
        @(negedge clk);
        ex_mthi = 1'b0; ex_mtlo = 1'b0;
        if (wh) exp_hi = d;
        if (wl) exp_lo = d;
        chk("mt_hilo", {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ex_div = 0; ex_mult = 0; ex_sign = 0;
        ex_op_a = 0; ex_op_b = 0;
        ex_mthi = 0; ex_mtlo = 0; ex_wdata = 0; flush = 0;
        exp_hi = 0; exp_lo = 0;
        #1;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_div", {div_a, div_b}, 64'd0);
        chk("rst_flags", {60'd0, div_fg, div_sg, stall, div_wrp}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_div(32'd100, 32'd7, 1'b0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        do_div(32'd1234, 32'd0, 1'b0);
        do_div(32'd9, 32'd3, 1'b0);

        // Flush ten cycles into WAIT, result must be discarded.
        @(negedge clk);
        ex_div = 1'b1; ex_op_a = 32'd77; ex_op_b = 32'd5;
        repeat (11) @(negedge clk);
        ex_div = 1'b0; flush = 1'b1;
        #1 chk("flush_wrp", {63'd0, div_wrp}, 64'd1);
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!div_wrp) break;
            n++;
            chk("drain_stall", {63'd0, stall}, 64'd0);
            @(negedge clk);
        end
        chk("drain_cyc", n, 2);
        chk("flush_hilo", {hi, lo}, {exp_hi, exp_lo});
        do_div(32'd20, 32'd6, 1'b0);

        do_mult(32'hFFFF_FFFF, 32'd2, 1'b1);
        do_mult(32'hFFFF_FFFF, 32'd2, 1'b0);
        do_mt(1'b1, 1'b1, 32'h1234);
        do_mt(1'b1, 1'b0, 32'h5678);
        do_mt(1'b0, 1'b1, 32'h5678);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        ex_div = 1'b1; ex_op_a = 32'd1000; ex_op_b = 32'd3;
        repeat (5) @(negedge clk);
        ex_div = 1'b0; rst = 1'b1;
        #1;
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_flags", {62'd0, div_fg, stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_hi = 0; exp_lo = 0;
        do_div(32'd5, 32'd5, 1'b0);

        for (int k = 0; k < 30; k++) begin
            logic [31:0] a, b;
            logic sg;
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            sg = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
            case ($urandom_range(0, 2))
                0: do_div(a, b, sg);
                1: do_mult(a, b, sg);
                default: do_mt(1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), a);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
